// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the QC-LDPC layered decoder: walks the layer datapath
// through every layer, runs the syndrome check, then terminates or iterates again.
module ldpc_iter_ctrl #(
  parameter int NUM_LAYERS = 16,
  parameter int LAYER_W    = 4,
  parameter int MAX_ITER   = 10,
  parameter int ITER_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               layer_en,
  output logic [LAYER_W-1:0] layer_idx,
  input  logic               layer_ack,
  output logic               judge,
  input  logic               judge_finish,
  input  logic               judge_flag,
  output logic               busy,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic               success,
  output logic [2:0]         dbg_state
);

  // Handshakes: layer_en/layer_ack completes one layer on any cycle where both
  // are high; dec_valid is held until the cycle dec_ready is sampled high.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAYER  = 3'd1,
    S_CHECK  = 3'd2,
    S_RESULT = 3'd3,
    S_OUT    = 3'd4
  } state_e;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [ITER_W-1:0]  ITER_LIMIT = ITER_W'(MAX_ITER);

  state_e               state_q, state_d;
  logic [LAYER_W-1:0]   layer_idx_q, layer_idx_d;
  logic [ITER_W-1:0]    iter_cnt_q, iter_cnt_d;
  logic                 success_q, success_d;
  logic [ITER_W-1:0]    iter_inc;

  assign iter_inc = iter_cnt_q + ITER_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_idx_q <= '0;
      iter_cnt_q  <= '0;
      success_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      iter_cnt_q  <= iter_cnt_d;
      success_q   <= success_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    iter_cnt_d  = iter_cnt_q;
    success_d   = success_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_cnt_d  = '0;
          layer_idx_d = '0;
          success_d   = 1'b0;
          state_d     = S_LAYER;
        end
      end
      S_LAYER: begin
        if (layer_ack) begin
          if (layer_idx_q == LAST_LAYER) begin
            layer_idx_d = '0;
            state_d     = S_CHECK;
          end else begin
            layer_idx_d = layer_idx_q + LAYER_W'(1);
          end
        end
      end
      // The checker resets its own step counter on finish, so nothing to count here.
      S_CHECK: begin
        if (judge_finish) state_d = S_RESULT;
      end
      S_RESULT: begin
        iter_cnt_d = iter_inc;
        if (judge_flag) begin
          success_d = 1'b1;
          state_d   = S_OUT;
        end else if (iter_inc == ITER_LIMIT) begin
          success_d = 1'b0;
          state_d   = S_OUT;
        end else begin
          state_d = S_LAYER;
        end
      end
      S_OUT: begin
        if (dec_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition and drops the frame without output.
    if (abort) begin
      state_d     = S_IDLE;
      layer_idx_d = '0;
      iter_cnt_d  = '0;
      success_d   = 1'b0;
    end
  end

  assign layer_en  = (state_q == S_LAYER);
  assign judge     = (state_q == S_CHECK);
  assign dec_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign layer_idx = layer_idx_q;
  assign iter_cnt  = iter_cnt_q;
  assign success   = success_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Bench for ldpc_iter_ctrl: directed timing scenarios plus randomized frames
// checked against a frame-level model (iterations, acks, success).
module tb_ldpc_iter_ctrl;
  localparam int NUM_LAYERS = 16;
  localparam int LAYER_W    = 4;
  localparam int MAX_ITER   = 10;
  localparam int ITER_W     = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, layer_ack = 1'b0;
  logic judge_finish = 1'b0, judge_flag = 1'b0, dec_ready = 1'b0;
  logic layer_en, judge, busy, dec_valid, success;
  logic [LAYER_W-1:0] layer_idx;
  logic [ITER_W-1:0]  iter_cnt;
  logic [2:0]         dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ldpc_iter_ctrl #(
    .NUM_LAYERS(NUM_LAYERS), .LAYER_W(LAYER_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_en(layer_en), .layer_idx(layer_idx), .layer_ack(layer_ack),
    .judge(judge), .judge_finish(judge_finish), .judge_flag(judge_flag),
    .busy(busy), .iter_cnt(iter_cnt), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .success(success), .dbg_state(dbg_state)
  );

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; layer_ack = 1'b0;
    judge_finish = 1'b0; judge_flag = 1'b0; dec_ready = 1'b0;
  endtask

  // Drives a frame with immediate acks and a 1-step check until OUT is seen.
  task automatic drive_until_out(input logic flag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0; layer_ack = 1'b1; judge_finish = judge; judge_flag = flag;
      if (dec_valid) begin ok = 1'b1; break; end
    end
    layer_ack = 1'b0; judge_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
      layer_ack = 1'($urandom_range(0, 1)); judge_finish = 1'($urandom_range(0, 1));
      judge_flag = 1'($urandom_range(0, 1)); dec_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({layer_en, judge, busy, dec_valid, success} !== 5'b0 || layer_idx !== '0 ||
          iter_cnt !== '0 || dbg_state !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs: got en=%b j=%b busy=%b dv=%b s=%b idx=%0d it=%0d st=%0d, required all 0",
                 layer_en, judge, busy, dec_valid, success, layer_idx, iter_cnt, dbg_state);
      end
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({layer_en, judge, busy, dec_valid, success} !== 5'b0 || layer_idx !== '0 || iter_cnt !== '0) begin
        errors++;
        $display("FAIL reset_idle: got en=%b j=%b busy=%b dv=%b s=%b, required all 0",
                 layer_en, judge, busy, dec_valid, success);
      end
    end
  endtask

  // Exact cycle timeline: start at cycle 0, acks tied high, 4-step check, pass.
  task automatic test_first_iter();
    int jcount = 0;
    bit exp_le, exp_j, exp_dv;
    idle_inputs();
    start = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      start = 1'b0; layer_ack = 1'b1; judge_flag = 1'b1; dec_ready = 1'b0;
      exp_le = (c >= 1 && c <= 16);
      exp_j  = (c >= 17 && c <= 20);
      exp_dv = (c == 22);
      checks++;
      if (layer_en !== exp_le || judge !== exp_j || dec_valid !== exp_dv) begin
        errors++;
        $display("FAIL first_iter_timeline c=%0d: got en=%b j=%b dv=%b, required en=%b j=%b dv=%b",
                 c, layer_en, judge, dec_valid, exp_le, exp_j, exp_dv);
      end
      if (exp_le) begin
        checks++;
        if (layer_idx !== LAYER_W'(c - 1)) begin
          errors++;
          $display("FAIL first_iter_layer_idx c=%0d: got %0d, required %0d", c, layer_idx, c - 1);
        end
      end
      if (judge) jcount++;
      judge_finish = judge && (jcount == 4);
      if (c == 22) begin
        checks++;
        if (success !== 1'b1 || iter_cnt !== ITER_W'(1)) begin
          errors++;
          $display("FAIL first_iter_result: got success=%b iter=%0d, required 1 and 1", success, iter_cnt);
        end
        dec_ready = 1'b1;
      end
      if (c == 23) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL first_iter_release: got busy=%b, required 0", busy);
        end
      end
    end
    idle_inputs();
  endtask

  // Reactive frame with random stalls, random check lengths and input noise.
  // conv = iteration whose check passes (0 or > MAX_ITER means never).
  task automatic run_frame(input int conv, input int max_stall, input string name);
    int exp_iters, acks, iter_done, exp_layer, jcount, jsteps, stall;
    bit exp_succ, fin_pending, done;
    exp_succ  = (conv >= 1 && conv <= MAX_ITER);
    exp_iters = exp_succ ? conv : MAX_ITER;
    acks = 0; iter_done = 0; exp_layer = 0; jcount = 0; fin_pending = 1'b0; done = 1'b0;
    jsteps = $urandom_range(1, 4);
    stall  = $urandom_range(0, max_stall);
    idle_inputs();
    start = 1'b1;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      start        = 1'($urandom_range(0, 1));
      layer_ack    = 1'($urandom_range(0, 1));
      judge_finish = 1'($urandom_range(0, 1));
      judge_flag   = 1'($urandom_range(0, 1));
      dec_ready    = 1'($urandom_range(0, 1));
      if (fin_pending) begin
        checks++;
        if (layer_en !== 1'b0 || judge !== 1'b0 || dec_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_result_cycle: got en=%b j=%b dv=%b busy=%b, required 0 0 0 1",
                   name, layer_en, judge, dec_valid, busy);
        end
        judge_flag = (iter_done + 1 == conv);
        iter_done++;
        fin_pending = 1'b0;
        dec_ready = 1'b0;
      end else if (layer_en) begin
        checks++;
        if (layer_idx !== LAYER_W'(exp_layer) || iter_cnt !== ITER_W'(iter_done) || judge !== 1'b0) begin
          errors++;
          $display("FAIL %s_layer: got idx=%0d iter=%0d j=%b, required idx=%0d iter=%0d j=0",
                   name, layer_idx, iter_cnt, judge, exp_layer, iter_done);
        end
        if (stall > 0) begin
          stall--;
          layer_ack = 1'b0;
        end else begin
          layer_ack = 1'b1;
          acks++;
          exp_layer = (exp_layer + 1) % NUM_LAYERS;
          stall = $urandom_range(0, max_stall);
          if (exp_layer == 0) begin
            jcount = 0;
            jsteps = $urandom_range(1, 4);
          end
        end
      end else if (judge) begin
        jcount++;
        judge_finish = (jcount == jsteps);
        fin_pending  = judge_finish;
        checks++;
        if (jcount > 4) begin
          errors++;
          $display("FAIL %s_judge_len: got %0d judge cycles, required at most %0d", name, jcount, jsteps);
        end
      end else if (dec_valid) begin
        checks++;
        if (success !== exp_succ || iter_cnt !== ITER_W'(exp_iters) ||
            acks != exp_iters * NUM_LAYERS || iter_done != exp_iters) begin
          errors++;
          $display("FAIL %s_out: got success=%b iter=%0d acks=%0d checks_run=%0d, required %b %0d %0d %0d",
                   name, success, iter_cnt, acks, iter_done, exp_succ, exp_iters,
                   exp_iters * NUM_LAYERS, exp_iters);
        end
        dec_ready = ($urandom_range(0, 2) == 0);
        done = dec_ready;
      end else begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_idle: got busy=%b, required 1", name, busy);
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got no accepted output, required one within budget", name);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_back_to_idle: got busy=%b dv=%b, required 0 0", name, busy, dec_valid);
    end
    idle_inputs();
  endtask

  task automatic test_nonconv();
    run_frame(0, 0, "nonconv");
  endtask

  task automatic test_conv3_stall();
    run_frame(3, 3, "conv3_stall");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) run_frame($urandom_range(0, 12), $urandom_range(0, 2), "random");
  endtask

  task automatic test_early_exit();
    bit seen = 1'b0;
    idle_inputs();
    start = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0; layer_ack = 1'b1;
      seen = judge;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL early_exit_timeout: got judge=%b, required 1", judge);
    end
    layer_ack = 1'b0; judge_finish = 1'b1; judge_flag = 1'b0;
    @(negedge clk);
    judge_finish = 1'b0;
    checks++;
    if (judge !== 1'b0 || layer_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_exit_result: got j=%b en=%b busy=%b, required 0 0 1", judge, layer_en, busy);
    end
    @(negedge clk);
    checks++;
    if (layer_en !== 1'b1 || layer_idx !== '0 || iter_cnt !== ITER_W'(1)) begin
      errors++;
      $display("FAIL early_exit_relayer: got en=%b idx=%0d iter=%0d, required 1 0 1", layer_en, layer_idx, iter_cnt);
    end
    abort = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    idle_inputs();
    start = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0; layer_ack = 1'b1; judge_finish = judge; judge_flag = 1'b0;
      hit = layer_en && layer_idx == LAYER_W'(7) && iter_cnt == ITER_W'(1);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach_timeout: got idx=%0d iter=%0d, required 7 1", layer_idx, iter_cnt);
    end
    layer_ack = 1'b0; judge_finish = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || layer_idx !== '0 || iter_cnt !== '0 || dec_valid !== 1'b0 ||
        success !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b idx=%0d iter=%0d dv=%b s=%b st=%0d, required all 0",
               busy, layer_idx, iter_cnt, dec_valid, success, dbg_state);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      layer_ack = 1'b1; judge_finish = 1'b1; dec_ready = 1'b1;
      checks++;
      if (busy !== 1'b0 || dec_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_stays_idle: got busy=%b dv=%b, required 0 0", busy, dec_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    bit ok;
    idle_inputs();
    start = 1'b1;
    drive_until_out(1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL backpressure_reach_timeout: got dv=%b, required 1", dec_valid);
    end
    for (int i = 0; i < 5; i++) begin
      dec_ready = 1'b0; start = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b1 || success !== 1'b1 || iter_cnt !== ITER_W'(1)) begin
        errors++;
        $display("FAIL backpressure_hold i=%0d: got dv=%b s=%b iter=%0d, required 1 1 1",
                 i, dec_valid, success, iter_cnt);
      end
    end
    dec_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || dec_valid !== 1'b0 || success !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_accept: got busy=%b dv=%b s=%b, required 0 0 1", busy, dec_valid, success);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_start_ignored: got busy=%b, required 0", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (layer_en !== 1'b1 || success !== 1'b0 || iter_cnt !== '0 || layer_idx !== '0) begin
      errors++;
      $display("FAIL restart_clears: got en=%b s=%b iter=%0d idx=%0d, required 1 0 0 0",
               layer_en, success, iter_cnt, layer_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 1'b0; layer_ack = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({layer_en, judge, busy, dec_valid, success} !== 5'b0 || layer_idx !== '0 || iter_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got en=%b j=%b busy=%b dv=%b idx=%0d, required all 0",
               layer_en, judge, busy, dec_valid, layer_idx);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got busy=%b dv=%b, required 0 0", busy, dec_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_iter();
    test_nonconv();
    test_conv3_stall();
    test_early_exit();
    test_abort();
    test_backpressure();
    test_random_frames();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_iter_ctrl.md
# ldpc_iter_ctrl

Iteration controller for the QC-LDPC layered decoder. It sequences the layer-update datapath through all layers of one decoding iteration, then drives the 4-step syndrome checker. It either terminates on a passing check or starts another iteration, up to a maximum iteration count. It sits between the frame input buffer / output stage and the decoder core, and owns the `judge` strobe consumed by the syndrome checker.

## Interface
- `NUM_LAYERS`, 16, layers per iteration (≥2).
- `LAYER_W`, 4, width of `layer_idx`; 2^LAYER_W ≥ NUM_LAYERS.
- `MAX_ITER`, 10, maximum iterations per frame (≥1).
- `ITER_W`, 5, width of `iter_cnt`; 2^ITER_W > MAX_ITER.

- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: frame loaded, begin decode; honoured only in IDLE.
- `abort` in 1: synchronous soft abort; returns to IDLE from any state.
- `layer_en` out 1: request datapath to update layer `layer_idx`.
- `layer_idx` out LAYER_W: current layer, 0..NUM_LAYERS-1.
- `layer_ack` in 1: datapath finished current layer; sampled only while `layer_en`=1.
- `judge` out 1: step strobe to the syndrome checker.
- `judge_finish` in 1: checker finish (combinational in checker).
- `judge_flag` in 1: checker registered result, 1 = all parities satisfied; valid the cycle after `judge_finish`.
- `busy` out 1: 1 in every state except IDLE.
- `iter_cnt` out ITER_W: completed iterations of the current frame.
- `dec_valid` out 1: decoded word available; held until `dec_ready`.
- `dec_ready` in 1: downstream accepts the word.
- `success` out 1: last frame converged; valid with `dec_valid`, held until next accepted `start`.

## Operation
- States: IDLE, LAYER, CHECK, RESULT, OUT.
- IDLE:
  - On `start`: clear `iter_cnt`, `layer_idx` and `success`, then go to LAYER.
  - Otherwise hold.
- LAYER:
  - `layer_en`=1.
  - On `layer_ack` with `layer_idx`<NUM_LAYERS-1: `layer_idx`++.
  - On `layer_ack` with `layer_idx`=NUM_LAYERS-1: `layer_idx`←0, go to CHECK.
  - Without `layer_ack`: hold with `layer_en` high.
- CHECK:
  - `judge`=1 every cycle in this state.
  - On `judge_finish`, go to RESULT.
  - The checker clears its own step counter on finish, so the controller needs no counter here.
- RESULT (one cycle):
  - Sample `judge_flag`.
  - `iter_cnt`←`iter_cnt`+1.
  - If `judge_flag`=1: `success`←1, go to OUT.
  - Else if `iter_cnt`+1=MAX_ITER: `success`←0, go to OUT.
  - Else go to LAYER.
- OUT:
  - `dec_valid`=1.
  - On `dec_ready`, go to IDLE.
  - `success` and `iter_cnt` stay stable.
- `abort` has priority over every transition:
  - Next state is IDLE.
  - `layer_idx`←0, `iter_cnt`←0, `success`←0.
  - No `dec_valid` is produced.
- Ignored inputs:
  - `start` outside IDLE, including the cycle `dec_ready` is accepted.
  - `layer_ack` outside LAYER.
  - `judge_finish` outside CHECK.
  - `dec_ready` outside OUT.
- `iter_cnt` never exceeds MAX_ITER. MAX_ITER=1 goes to OUT after the first RESULT regardless of flag.

## Timing
- Reset values:
  - State IDLE.
  - `layer_en`, `judge`, `busy`, `dec_valid`, `success` = 0.
  - `layer_idx`, `iter_cnt` = 0.
  - Asserting `rst_n` mid-decode behaves the same (async clear), with no partial output.
- `layer_en`, `judge`, `busy`, `dec_valid` are decoded from registered state. They are glitch-free and have no combinational path from inputs.
- `start` sampled at edge N gives `layer_en`=1 from cycle N+1.
- Each layer takes at least 1 cycle; `layer_ack` may arrive in the first cycle of `layer_en`.
- CHECK lasts 1–4 cycles, set by the checker.
- RESULT takes 1 cycle, and `judge_flag` is sampled there (one cycle after `judge_finish`).
- Minimum iteration = NUM_LAYERS + 1 + 1 cycles. Typical iteration with `layer_ack` tied 1 and a full 4-step check = NUM_LAYERS + 5 cycles.
- `dec_valid` rises the cycle after the terminating RESULT. It falls the cycle after `dec_ready` is sampled high.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0 and state IDLE. Release, drive no `start` → outputs stay 0.
- Converge first iteration (defaults): `start` at cycle 0, `layer_ack`=1, checker finishes on 4th `judge`, `judge_flag`=1 →
  - `layer_en` high cycles 1–16 with `layer_idx` 0..15.
  - `judge` high cycles 17–20.
  - `dec_valid`=1 at cycle 22 with `success`=1, `iter_cnt`=1.
- Non-convergence: `judge_flag` always 0 → exactly 10 iterations and 160 layer acks; `dec_valid` with `success`=0, `iter_cnt`=10.
- Convergence at iteration 3, with `layer_ack` randomly stalled 0–3 cycles → `layer_idx` holds during stalls; `iter_cnt`=3, `success`=1; exactly 48 `layer_ack` consumed.
- Early checker exit: `judge_finish` on 1st `judge` cycle with `judge_flag`=0 → `judge` high for 1 cycle only; next cycle RESULT; the one after, LAYER with `layer_idx`=0.
- Abort and backpressure:
  - `abort` while `layer_idx`=7 → next cycle IDLE, `layer_idx`=0, no `dec_valid`.
  - Separately, hold `dec_ready`=0 for 5 cycles in OUT while pulsing `start` → `dec_valid` and `success` stable and `start` ignored; IDLE one cycle after `dec_ready`.
